// File: rtl/ultrasonic_ranger.sv
// HC-SR04 ranging front-end: trigger generation, echo-width measurement and
// centimetre conversion through a per-centimetre cycle prescaler.
module ultrasonic_ranger #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int TRIG_US     = 10,
    parameter int CM_US       = 58,
    parameter int WAIT_TO_US  = 5000,
    parameter int MAX_CM      = 400,
    parameter int HOLDOFF_US  = 60000,
    parameter int DIST_W      = 9
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              enable,
    input  logic              start,
    input  logic              echo,
    output logic              trig,
    output logic              busy,
    output logic [DIST_W-1:0] distance_cm,
    output logic              valid,
    output logic              timeout
);
    localparam int CLK_PER_US = CLK_FREQ_HZ / 1000000;
    localparam int TRIG_CYC   = TRIG_US * CLK_PER_US;
    localparam int CLK_PER_CM = CM_US * CLK_PER_US;
    localparam int WAIT_CYC   = WAIT_TO_US * CLK_PER_US;
    localparam int HOLD_CYC   = HOLDOFF_US * CLK_PER_US;
    localparam int CYC_MAX_A  = (TRIG_CYC > WAIT_CYC) ? TRIG_CYC : WAIT_CYC;
    localparam int CYC_MAX    = (CYC_MAX_A > HOLD_CYC) ? CYC_MAX_A : HOLD_CYC;
    localparam int CYC_W      = $clog2(CYC_MAX + 1);
    localparam int PRE_W      = $clog2(CLK_PER_CM + 1);
    localparam int CM_W       = $clog2(MAX_CM + 1);

    localparam logic [CYC_W-1:0]  TRIG_LAST = CYC_W'(TRIG_CYC - 1);
    localparam logic [CYC_W-1:0]  WAIT_LAST = CYC_W'(WAIT_CYC - 1);
    localparam logic [CYC_W-1:0]  HOLD_LAST = CYC_W'(HOLD_CYC - 1);
    localparam logic [CYC_W-1:0]  CYC_ONE   = CYC_W'(1);
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_PER_CM - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE   = PRE_W'(1);
    localparam logic [CM_W-1:0]   CM_SAT    = CM_W'(MAX_CM);
    localparam logic [CM_W-1:0]   CM_ONE    = CM_W'(1);
    localparam logic [DIST_W-1:0] DIST_SAT  = DIST_W'(MAX_CM);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_ECHO = 3'd2,
        MEASURE   = 3'd3,
        HOLDOFF   = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [CYC_W-1:0]  cyc_next;
    logic [PRE_W-1:0]  pre;
    logic [PRE_W-1:0]  pre_next;
    logic [CM_W-1:0]   cm_cnt;
    logic [CM_W-1:0]   cm_next;
    logic [CM_W-1:0]   cm_tick;
    logic              pre_wrap;
    logic              trig_next;
    logic              valid_next;
    logic              timeout_next;
    logic [DIST_W-1:0] dist_next;
    logic              echo_meta;
    logic              echo_s;
    logic              echo_d;
    logic              rise;
    logic              fall;

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;

    // Two-flop synchroniser for the asynchronous echo pin plus an edge-detect delay stage.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            echo_meta <= 1'b0;
            echo_s    <= 1'b0;
            echo_d    <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_s    <= echo_meta;
            echo_d    <= echo_s;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state       <= IDLE;
            cyc_cnt     <= '0;
            pre         <= '0;
            cm_cnt      <= '0;
            trig        <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
            distance_cm <= '0;
        end else begin
            state       <= state_next;
            cyc_cnt     <= cyc_next;
            pre         <= pre_next;
            cm_cnt      <= cm_next;
            trig        <= trig_next;
            busy        <= (state_next != IDLE);
            valid       <= valid_next;
            timeout     <= timeout_next;
            distance_cm <= dist_next;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_next   = state;
        cyc_next     = cyc_cnt;
        pre_next     = pre;
        cm_next      = cm_cnt;
        trig_next    = 1'b0;
        valid_next   = 1'b0;
        timeout_next = timeout;
        dist_next    = distance_cm;
        pre_wrap     = (pre == PRE_LAST);
        // The cycle in which the fall is seen still counts toward the width.
        cm_tick      = pre_wrap ? (cm_cnt + CM_ONE) : cm_cnt;

        case (state)
            IDLE: begin
                if (start | enable) begin
                    state_next = TRIG;
                    cyc_next   = '0;
                    trig_next  = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            TRIG: begin
                if (cyc_cnt == TRIG_LAST) begin
                    state_next = WAIT_ECHO;
                    cyc_next   = '0;
                end else begin
                    trig_next  = 1'b1;
                    cyc_next   = cyc_cnt + CYC_ONE;
                end
            end
            WAIT_ECHO: begin
                if (rise) begin
                    state_next = MEASURE;
                    pre_next   = '0;
                    cm_next    = '0;
                end else if (cyc_cnt == WAIT_LAST) begin
                    state_next   = HOLDOFF;
                    cyc_next     = '0;
                    dist_next    = DIST_SAT;
                    timeout_next = 1'b1;
                    valid_next   = 1'b1;
                end else begin
                    cyc_next = cyc_cnt + CYC_ONE;
                end
            end
            MEASURE: begin
                if (fall) begin
                    state_next   = HOLDOFF;
                    cyc_next     = '0;
                    dist_next    = DIST_W'(cm_tick);
                    timeout_next = 1'b0;
                    valid_next   = 1'b1;
                end else if (cm_tick == CM_SAT) begin
                    state_next   = HOLDOFF;
                    cyc_next     = '0;
                    dist_next    = DIST_SAT;
                    timeout_next = 1'b1;
                    valid_next   = 1'b1;
                end else begin
                    pre_next = pre_wrap ? '0 : (pre + PRE_ONE);
                    cm_next  = cm_tick;
                end
            end
            HOLDOFF: begin
                if (cyc_cnt == HOLD_LAST) begin
                    // A stuck-high echo keeps us here so it cannot be mistaken for a new rise.
                    if (!echo_s) begin
                        state_next = IDLE;
                    end else begin
                        state_next = HOLDOFF;
                    end
                end else begin
                    cyc_next = cyc_cnt + CYC_ONE;
                end
            end
            default: begin
                state_next = IDLE;
                cyc_next   = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed self-checking bench for ultrasonic_ranger at 1 MHz (1 cycle = 1 us).
module tb_ultrasonic_ranger;
    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic       enable;
    logic       start;
    logic       echo;
    logic       trig;
    logic       busy;
    logic [8:0] distance_cm;
    logic       valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int valid_pulses = 0;

    always #5 clk_clk = ~clk_clk;

    ultrasonic_ranger #(
        .CLK_FREQ_HZ(1000000),
        .TRIG_US    (10),
        .CM_US      (58),
        .WAIT_TO_US (5000),
        .MAX_CM     (400),
        .HOLDOFF_US (100),
        .DIST_W     (9)
    ) dut (
        .clk_clk    (clk_clk),
        .reset_reset(reset_reset),
        .enable     (enable),
        .start      (start),
        .echo       (echo),
        .trig       (trig),
        .busy       (busy),
        .distance_cm(distance_cm),
        .valid      (valid),
        .timeout    (timeout)
    );

    always @(negedge clk_clk) begin
        if (valid === 1'b1) valid_pulses++;
    end

    // which: 0 trig high, 1 trig low, 2 valid high, 3 busy low
    task automatic wait_until(input int which, input int limit, output int cycles, output bit ok);
        cycles = 0;
        ok = 1'b0;
        while (cycles < limit && !ok) begin
            @(negedge clk_clk);
            cycles++;
            case (which)
                0: ok = (trig === 1'b1);
                1: ok = (trig === 1'b0);
                2: ok = (valid === 1'b1);
                3: ok = (busy === 1'b0);
                default: ok = 1'b1;
            endcase
        end
    endtask

    task automatic pulse_start();
        @(negedge clk_clk);
        start = 1'b1;
        @(negedge clk_clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        enable = 1'b0;
        start = 1'b0;
        echo = 1'b0;
        repeat (3) @(negedge clk_clk);
        checks++;
        if ({trig, busy, valid, timeout} !== 4'b0000 || distance_cm !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: trig=%b busy=%b valid=%b timeout=%b dist=%0d, expected all 0",
                     trig, busy, valid, timeout, distance_cm);
        end
        reset_reset = 1'b0;
        repeat (3) @(negedge clk_clk);
        checks++;
        if (busy !== 1'b0 || trig !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b trig=%b, expected 0 0", busy, trig);
        end
    endtask

    task automatic test_single_shot();
        int width;
        int cyc;
        int v0;
        bit ok;
        v0 = valid_pulses;
        @(negedge clk_clk);
        start = 1'b1;
        @(negedge clk_clk);
        start = 1'b0;
        width = 0;
        while (trig === 1'b1 && width < 50) begin
            width++;
            @(negedge clk_clk);
        end
        checks++;
        if (width !== 10) begin
            errors++;
            $display("FAIL trig_width: got %0d cycles, expected 10", width);
        end
        repeat (20) @(negedge clk_clk);
        echo = 1'b1;
        repeat (580) @(negedge clk_clk);
        echo = 1'b0;
        wait_until(2, 20, cyc, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_valid_seen: no valid within %0d cycles, expected one", cyc);
        end
        checks++;
        if (distance_cm !== 9'd10 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_result: dist=%0d timeout=%b, expected 10 0", distance_cm, timeout);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_during_holdoff: got %b, expected 1", busy);
        end
        @(negedge clk_clk);
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_one_cycle: got %b on second cycle, expected 0", valid);
        end
        wait_until(3, 200, cyc, ok);
        checks++;
        if (!ok || (cyc + 1) < 99 || (cyc + 1) > 101) begin
            errors++;
            $display("FAIL holdoff_length: busy cleared after %0d cycles (ok=%b), expected 100", cyc + 1, ok);
        end
        repeat (5) @(negedge clk_clk);
        checks++;
        if (valid_pulses - v0 !== 1) begin
            errors++;
            $display("FAIL single_valid_count: got %0d pulses, expected 1", valid_pulses - v0);
        end
    endtask

    task automatic test_no_echo();
        int cyc;
        bit ok;
        pulse_start();
        wait_until(1, 30, cyc, ok);
        wait_until(2, 5100, cyc, ok);
        checks++;
        if (!ok || cyc < 4999 || cyc > 5001) begin
            errors++;
            $display("FAIL no_echo_latency: valid after %0d cycles (ok=%b), expected 5000", cyc, ok);
        end
        checks++;
        if (distance_cm !== 9'd400 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL no_echo_result: dist=%0d timeout=%b, expected 400 1", distance_cm, timeout);
        end
        wait_until(3, 200, cyc, ok);
    endtask

    task automatic test_over_range();
        int cyc;
        int v0;
        bit ok;
        v0 = valid_pulses;
        pulse_start();
        wait_until(1, 30, cyc, ok);
        repeat (5) @(negedge clk_clk);
        echo = 1'b1;
        wait_until(2, 24000, cyc, ok);
        checks++;
        if (!ok || cyc < 23200 || cyc > 23206) begin
            errors++;
            $display("FAIL sat_latency: valid %0d cycles after echo rise (ok=%b), expected about 23203", cyc, ok);
        end
        checks++;
        if (distance_cm !== 9'd400 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL sat_result: dist=%0d timeout=%b, expected 400 1", distance_cm, timeout);
        end
        repeat (6500) @(negedge clk_clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL stuck_echo_busy: got %b, expected 1", busy);
        end
        echo = 1'b0;
        wait_until(3, 10, cyc, ok);
        checks++;
        if (!ok || cyc > 5) begin
            errors++;
            $display("FAIL stuck_echo_release: busy cleared after %0d cycles (ok=%b), expected <=5", cyc, ok);
        end
        repeat (3) @(negedge clk_clk);
        checks++;
        if (valid_pulses - v0 !== 1) begin
            errors++;
            $display("FAIL sat_valid_count: got %0d pulses, expected 1", valid_pulses - v0);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int v0;
        int busy_hi;
        bit ok;
        v0 = valid_pulses;
        @(negedge clk_clk);
        enable = 1'b1;
        for (int m = 0; m < 3; m++) begin
            wait_until(0, 300, cyc, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL b2b_retrigger: measurement %0d did not start within %0d cycles", m, cyc);
            end
            wait_until(1, 30, cyc, ok);
            if (m == 2) begin
                enable = 1'b0;
                pulse_start();
                repeat (8) @(negedge clk_clk);
            end else begin
                repeat (10) @(negedge clk_clk);
            end
            echo = 1'b1;
            repeat (1160) @(negedge clk_clk);
            echo = 1'b0;
            wait_until(2, 20, cyc, ok);
            checks++;
            if (!ok || distance_cm !== 9'd20 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL b2b_result: measurement %0d ok=%b dist=%0d timeout=%b, expected 20 0",
                         m, ok, distance_cm, timeout);
            end
        end
        wait_until(3, 300, cyc, ok);
        busy_hi = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_clk);
            if (busy === 1'b1 || trig === 1'b1) busy_hi++;
        end
        checks++;
        if (!ok || busy_hi !== 0) begin
            errors++;
            $display("FAIL b2b_stop: ok=%b busy/trig high %0d cycles after enable cleared, expected 0", ok, busy_hi);
        end
        checks++;
        if (valid_pulses - v0 !== 3) begin
            errors++;
            $display("FAIL b2b_valid_count: got %0d pulses, expected 3", valid_pulses - v0);
        end
    endtask

    task automatic test_reset_mid_measure();
        int cyc;
        bit ok;
        pulse_start();
        wait_until(1, 30, cyc, ok);
        repeat (5) @(negedge clk_clk);
        echo = 1'b1;
        repeat (50) @(negedge clk_clk);
        reset_reset = 1'b1;
        #1;
        checks++;
        if ({trig, busy, valid, timeout} !== 4'b0000 || distance_cm !== 9'd0) begin
            errors++;
            $display("FAIL async_reset: trig=%b busy=%b valid=%b timeout=%b dist=%0d, expected all 0",
                     trig, busy, valid, timeout, distance_cm);
        end
        repeat (3) @(negedge clk_clk);
        reset_reset = 1'b0;
        repeat (3) @(negedge clk_clk);
        pulse_start();
        wait_until(1, 30, cyc, ok);
        wait_until(2, 5100, cyc, ok);
        checks++;
        if (!ok || distance_cm !== 9'd400 || timeout !== 1'b1) begin
            errors++;
            $display("FAIL stale_echo: ok=%b dist=%0d timeout=%b, expected 400 1", ok, distance_cm, timeout);
        end
        echo = 1'b0;
        wait_until(3, 300, cyc, ok);
    endtask

    task automatic test_truncation();
        int widths [2] = '{637, 57};
        int expect_cm [2] = '{10, 0};
        int cyc;
        bit ok;
        for (int k = 0; k < 2; k++) begin
            pulse_start();
            wait_until(1, 30, cyc, ok);
            repeat (10) @(negedge clk_clk);
            echo = 1'b1;
            repeat (widths[k]) @(negedge clk_clk);
            echo = 1'b0;
            wait_until(2, 20, cyc, ok);
            checks++;
            if (!ok || distance_cm !== 9'(expect_cm[k]) || timeout !== 1'b0) begin
                errors++;
                $display("FAIL truncation_w%0d: ok=%b dist=%0d timeout=%b, expected %0d 0",
                         widths[k], ok, distance_cm, timeout, expect_cm[k]);
            end
            wait_until(3, 300, cyc, ok);
        end
    endtask

    initial begin
        test_reset();
        test_single_shot();
        test_no_echo();
        test_over_range();
        test_back_to_back();
        test_reset_mid_measure();
        test_truncation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
